// File: rtl/conv_encoder_if.sv
// Source bit handshake and coded-symbol output bundle for conv_encoder.
// The slave side is the encoder; the master side feeds bits and consumes symbols.
interface conv_encoder_if;
    logic       s_valid;
    logic       s_data;
    logic       s_ready;
    logic [1:0] d_out;
    logic       d_valid;
    logic       frame_start;
    logic       frame_last;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  d_out,
        input  d_valid,
        input  frame_start,
        input  frame_last
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output d_out,
        output d_valid,
        output frame_start,
        output frame_last
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 K=4 convolutional encoder (g0=17, g1=15 octal) with an input bit FIFO,
// fixed-length framing and a 3-symbol zero tail that returns the trellis to state 000.
module conv_encoder #(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    conv_encoder_if.slave  bus,
    output logic           underrun
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [9:0]  DataLast = 10'(FRAME_LEN - 4);
    localparam logic [9:0]  TailLast = 10'(FRAME_LEN - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    state_e          state_q, state_d;
    logic [2:0]      enc_q, enc_d;
    logic [9:0]      sym_cnt_q, sym_cnt_d;
    logic            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic            s_ready_q, s_ready_d;
    logic [1:0]      d_out_q, d_out_d;
    logic            d_valid_q, d_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_last_q, frame_last_d;
    logic            underrun_q, underrun_d;

    logic push, pop, encode, bit_in;

    assign push = bus.s_valid && s_ready_q;

    always_comb begin
        state_d       = state_q;
        enc_d         = enc_q;
        sym_cnt_d     = sym_cnt_q;
        underrun_d    = underrun_q;
        pop           = 1'b0;
        encode        = 1'b0;
        bit_in        = 1'b0;
        frame_start_d = 1'b0;
        frame_last_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StData;
                    sym_cnt_d = '0;
                    enc_d     = '0;
                end
            end
            StData: begin
                if (!enable) begin
                    state_d   = StIdle;
                    enc_d     = '0;
                    sym_cnt_d = '0;
                end else begin
                    encode = 1'b1;
                    // An empty slot is stuffed with 0; a same-cycle push is not bypassed.
                    if (fifo_cnt_q != '0) begin
                        pop    = 1'b1;
                        bit_in = mem_q[rd_ptr_q];
                    end else begin
                        underrun_d = 1'b1;
                    end
                    frame_start_d = (sym_cnt_q == '0);
                    sym_cnt_d     = sym_cnt_q + 10'd1;
                    if (sym_cnt_q == DataLast) begin
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                if (!enable) begin
                    state_d   = StIdle;
                    enc_d     = '0;
                    sym_cnt_d = '0;
                end else begin
                    encode       = 1'b1;
                    frame_last_d = (sym_cnt_q == TailLast);
                    sym_cnt_d    = sym_cnt_q + 10'd1;
                    if (sym_cnt_q == TailLast) begin
                        state_d   = StData;
                        sym_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                enc_d     = '0;
                sym_cnt_d = '0;
            end
        endcase

        if (!enable) begin
            underrun_d = 1'b0;
        end

        d_valid_d = encode;
        d_out_d   = 2'b00;
        if (encode) begin
            d_out_d = {bit_in ^ enc_q[2] ^ enc_q[1] ^ enc_q[0], bit_in ^ enc_q[2] ^ enc_q[0]};
            enc_d   = {bit_in, enc_q[2:1]};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        s_ready_d = (fifo_cnt_d != FullCnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            enc_q         <= '0;
            sym_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            s_ready_q     <= 1'b0;
            d_out_q       <= 2'b00;
            d_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            enc_q         <= enc_d;
            sym_cnt_q     <= sym_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            s_ready_q     <= s_ready_d;
            d_out_q       <= d_out_d;
            d_valid_q     <= d_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            underrun_q    <= underrun_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.d_out       = d_out_q;
    assign bus.d_valid     = d_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_last  = frame_last_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder with FRAME_LEN=8, FIFO_DEPTH=4: impulse, back-to-back,
// starvation, backpressure, abort/re-enable and asynchronous reset.
module tb_conv_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic underrun;

    conv_encoder_if bus ();

    conv_encoder #(
        .FRAME_LEN  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit feed_q [$];

    // Hand-computed symbol streams, {g0,g1} per symbol.
    logic [1:0] exp_f1 [8] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_f2 [8] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00};
    logic [1:0] exp_f3 [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_f4 [8] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_f5 [8] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_frame(input string name, input logic [1:0] exp [8],
                               input logic [7:0] urun, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step();
            check($sformatf("%s sym%0d d_valid", name, i), 32'(bus.d_valid), 32'd1);
            check($sformatf("%s sym%0d d_out", name, i), 32'(bus.d_out), 32'(exp[i]));
            check($sformatf("%s sym%0d frame_start", name, i), 32'(bus.frame_start),
                  32'(i == 0));
            check($sformatf("%s sym%0d frame_last", name, i), 32'(bus.frame_last),
                  32'(i == 7));
            check($sformatf("%s sym%0d underrun", name, i), 32'(underrun), 32'(urun[i]));
        end
    endtask

    // Source driver: offers the head of feed_q, retires it when accepted.
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.s_valid && bus.s_ready && feed_q.size() != 0) begin
                void'(feed_q.pop_front());
            end
            #1;
            bus.s_valid = (feed_q.size() != 0);
            bus.s_data  = (feed_q.size() != 0) ? feed_q[0] : 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("reset s_ready", 32'(bus.s_ready), 32'd0);
        check("reset d_valid", 32'(bus.d_valid), 32'd0);
        check("reset d_out", 32'(bus.d_out), 32'd0);
        check("reset frame_start", 32'(bus.frame_start), 32'd0);
        check("reset frame_last", 32'(bus.frame_last), 32'd0);
        check("reset underrun", 32'(underrun), 32'd0);
        #1 rst = 1'b1;
        step();
        check("s_ready after release", 32'(bus.s_ready), 32'd1);

        // Backpressure in IDLE: four accepted, the fifth held off.
        feed_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (6) step();
        check("full s_ready", 32'(bus.s_ready), 32'd0);
        check("idle d_valid", 32'(bus.d_valid), 32'd0);
        check("held bits", 32'(feed_q.size()), 32'd1);
        feed_q.push_back(1'b1);
        feed_q.push_back(1'b1);
        feed_q.push_back(1'b0);
        feed_q.push_back(1'b1);
        feed_q.push_back(1'b0);

        enable = 1'b1;
        step();
        check("enable edge d_valid", 32'(bus.d_valid), 32'd0);
        check_frame("impulse", exp_f1, 8'h00, 0, 0);
        check("s_ready after first pop", 32'(bus.s_ready), 32'd1);
        check_frame("impulse", exp_f1, 8'h00, 1, 7);
        check_frame("b2b", exp_f2, 8'h00, 0, 7);
        check_frame("starve", exp_f3, 8'hff, 0, 3);

        enable = 1'b0;
        step();
        check("starve abort d_valid", 32'(bus.d_valid), 32'd0);
        check("starve abort underrun", 32'(underrun), 32'd0);
        check("starve abort frame_start", 32'(bus.frame_start), 32'd0);

        feed_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        repeat (6) step();
        check("refill s_ready", 32'(bus.s_ready), 32'd0);
        enable = 1'b1;
        step();
        check_frame("abort", exp_f4, 8'h00, 0, 3);
        enable = 1'b0;
        step();
        check("abort d_valid", 32'(bus.d_valid), 32'd0);
        check("abort d_out", 32'(bus.d_out), 32'd0);
        step();
        enable = 1'b1;
        step();
        check_frame("resume", exp_f5, 8'hf0, 0, 7);
        enable = 1'b0;
        step();
        check("post-frame d_valid", 32'(bus.d_valid), 32'd0);
        check("post-frame underrun", 32'(underrun), 32'd0);

        // Asynchronous reset between clock edges, mid-DATA.
        feed_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        repeat (5) step();
        enable = 1'b1;
        repeat (3) step();
        check("pre-reset d_valid", 32'(bus.d_valid), 32'd1);
        #3;
        rst = 1'b0;
        enable = 1'b0;
        feed_q.delete();
        #1;
        check("async d_valid", 32'(bus.d_valid), 32'd0);
        check("async d_out", 32'(bus.d_out), 32'd0);
        check("async s_ready", 32'(bus.s_ready), 32'd0);
        check("async frame_start", 32'(bus.frame_start), 32'd0);
        #2 rst = 1'b1;
        step();
        check("rearm s_ready", 32'(bus.s_ready), 32'd1);
        check("rearm d_valid", 32'(bus.d_valid), 32'd0);
        enable = 1'b1;
        step();
        step();
        check("flushed d_valid", 32'(bus.d_valid), 32'd1);
        check("flushed d_out", 32'(bus.d_out), 32'd0);
        check("flushed underrun", 32'(underrun), 32'd1);
        check("flushed frame_start", 32'(bus.frame_start), 32'd1);
        step();
        check("flushed underrun sticky", 32'(underrun), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter FRAME_LEN, 1024, total coded symbols per frame including tail; legal range 8..1024.
REQ-002 Parameter FIFO_DEPTH, 4, input bit FIFO depth; power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 enable  input  1  stream enable; low aborts or holds the encoder idle.
REQ-006 s_valid  input  1  source bit valid.
REQ-007 s_data  input  1  source information bit.
REQ-008 s_ready  output  1  FIFO can accept a bit; equals not-full and is registered.
REQ-009 d_out  output  2  coded symbol; [1]=g0 parity, [0]=g1 parity.
REQ-010 d_valid  output  1  d_out holds a valid symbol this cycle.
REQ-011 frame_start  output  1  one-cycle pulse with the first symbol of a frame.
REQ-012 frame_last  output  1  one-cycle pulse with the last tail symbol of a frame.
REQ-013 underrun  output  1  sticky flag: a data slot found the FIFO empty.

Function
REQ-014 Code: rate 1/2, K=4, g0=1111 (octal 17), g1=1101 (octal 15); 3-bit state s[2:0], with s[2] the most recent bit.
REQ-015 Per encoded bit b: g0 = b^s2^s1^s0; g1 = b^s2^s0; next state = {b, s[2:1]}. This matches the 8-state trellis numbering used by the decoder.
REQ-016 Push occurs when s_valid && s_ready; bits are popped in FIFO order, one per DATA cycle.
REQ-017 FSM states: IDLE, DATA, TAIL.
REQ-018 IDLE: d_valid=0; no pops. Go to DATA on the cycle enable=1.
REQ-019 DATA: every cycle, encode one bit and increment the symbol counter. Bit source: FIFO pop if non-empty; otherwise b=0 with no pop, and underrun is set.
REQ-020 DATA lasts exactly FRAME_LEN-3 cycles, then goes to TAIL.
REQ-021 TAIL: exactly 3 cycles encoding b=0 with no pops; the state returns to 000.
REQ-022 After TAIL: go to DATA with no gap cycle if enable=1; otherwise go to IDLE.
REQ-023 Symbol counter: 10 bits; cleared on entry to each frame; wrap-free within the legal FRAME_LEN range.
REQ-024 Output timing: d_out, d_valid, frame_start and frame_last are registered; a symbol appears one cycle after its encode cycle.
REQ-025 While enable=1 and a frame is in progress, d_valid=1 every cycle, giving a continuous stream for the decoder.
REQ-026 frame_start asserts with symbol 0; frame_last asserts with symbol FRAME_LEN-1.
REQ-027 Simultaneous push and pop: both take effect, and the FIFO count is unchanged.
REQ-028 Push into an empty FIFO in a DATA cycle is not bypassed; that slot is stuffed with 0 and underrun is set.
REQ-029 s_ready is deasserted at count==FIFO_DEPTH and reasserts the cycle after a pop.
REQ-030 enable low mid-frame, on the next edge:
- FSM goes to IDLE.
- s and the counter clear.
- d_valid, frame_start and frame_last go to 0.
- underrun clears.
- FIFO contents are retained.
REQ-031 FIFO accepts pushes in every FSM state, including IDLE.

Reset
REQ-032 On rst low:
- FSM=IDLE, s=000, counter=0.
- FIFO empty; s_ready=0 while rst is low, 1 on the first edge after release.
- d_out=00, d_valid=0, frame_start=0, frame_last=0, underrun=0.
REQ-033 Reset asserted mid-frame discards the frame and FIFO contents immediately; no symbol is emitted until enable is seen high after release.

Verification
REQ-034 Impulse: FRAME_LEN=8; push bits 1,0,0,0,0; enable=1.
- d_out = 11,11,10,11,00, then tail 00,00,00.
- frame_start on symbol 0, frame_last on symbol 7, underrun=0.
REQ-035 Back-to-back frames: FIFO kept fed, FRAME_LEN=8, enable held high.
- frame_last is followed the next cycle by frame_start.
- No d_valid gap.
- State is 000 at each frame start.
REQ-036 Starvation: FIFO empty at enable.
- d_out=00 each slot; underrun=1 after the first DATA cycle and stays set.
- enable low for one cycle clears underrun.
REQ-037 Backpressure: hold s_valid=1 with the FSM in IDLE.
- s_ready drops after 4 accepted bits.
- After enable, the 4 bits are encoded in order; s_ready returns 1 one cycle after the first pop.
REQ-038 Abort: deassert enable at symbol 3 of a frame.
- d_valid=0 on the next cycle.
- Re-enable: the new frame starts with state 000, frame_start=1, and the unpopped FIFO bits are encoded first.
REQ-039 Async reset pulse mid-DATA (not clock-aligned):
- Outputs go to reset values without waiting for a clock edge.
- FIFO empty after release.
